// File: rtl/dtlb_sched_pkg.sv
// dtlb_sched_pkg: shared types and sizing for the DTLB miss scheduler.
//   miss_entry_t  : one pending-miss table entry (valid, issued, vpn, waiters)
//   sched_state_e : walk scheduler states
//   pr_lowest     : priority encoder, index of the lowest set bit (0 if none)
package dtlb_sched_pkg;

    localparam int REQ_NUM   = 4;
    localparam int ENTRY_NUM = 4;
    localparam int VPN_WIDTH = 27;
    localparam int TAG_W     = $clog2(ENTRY_NUM);

    typedef struct packed {
        logic                 valid;
        logic                 issued;
        logic [VPN_WIDTH-1:0] vpn;
        logic [REQ_NUM-1:0]   waiters;
    } miss_entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } sched_state_e;

    function automatic int unsigned pr_lowest(input logic [31:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dtlb_miss_match.sv
// dtlb_miss_match: combinational request-vs-table matcher.
//   entries     : current pending-miss table
//   exclude     : entries that must not accept merges (freed this cycle)
//   req_valid   : per-requester miss valid
//   req_vpn     : packed per-requester VPNs
//   merge_vec   : per entry, the requesters merging into it
//   merge_hit   : requester hit an existing entry
//   alloc_valid : a new entry is allocated this cycle
//   alloc_idx   : lowest free entry
//   alloc_vpn   : VPN stored into the new entry
//   alloc_mask  : requesters joining the new entry
module dtlb_miss_match
    import dtlb_sched_pkg::*;
(
    input  miss_entry_t [ENTRY_NUM-1:0]              entries,
    input  logic        [ENTRY_NUM-1:0]              exclude,
    input  logic        [REQ_NUM-1:0]                req_valid,
    input  logic        [REQ_NUM*VPN_WIDTH-1:0]      req_vpn,
    output logic        [ENTRY_NUM-1:0][REQ_NUM-1:0] merge_vec,
    output logic        [REQ_NUM-1:0]                merge_hit,
    output logic                                     alloc_valid,
    output logic        [TAG_W-1:0]                  alloc_idx,
    output logic        [VPN_WIDTH-1:0]              alloc_vpn,
    output logic        [REQ_NUM-1:0]                alloc_mask
);

    logic [REQ_NUM-1:0]   nonmerge;
    logic [ENTRY_NUM-1:0] free_vec;
    int unsigned          first_req;

    always_comb begin
        merge_vec = '0;
        merge_hit = '0;
        free_vec  = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            for (int e = 0; e < ENTRY_NUM; e++) begin
                if (req_valid[i] && entries[e].valid && !exclude[e] && !merge_hit[i] &&
                    entries[e].vpn == req_vpn[i*VPN_WIDTH +: VPN_WIDTH]) begin
                    merge_vec[e][i] = 1'b1;
                    merge_hit[i]    = 1'b1;
                end
            end
        end
        for (int e = 0; e < ENTRY_NUM; e++) free_vec[e] = !entries[e].valid;

        nonmerge    = req_valid & ~merge_hit;
        first_req   = pr_lowest(32'(nonmerge));
        alloc_valid = (|nonmerge) && (|free_vec);
        alloc_idx   = TAG_W'(pr_lowest(32'(free_vec)));
        alloc_vpn   = req_vpn[first_req*VPN_WIDTH +: VPN_WIDTH];

        // Everyone missing on the allocating requester's VPN rides the same new entry.
        alloc_mask = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (alloc_valid && nonmerge[i] && req_vpn[i*VPN_WIDTH +: VPN_WIDTH] == alloc_vpn)
                alloc_mask[i] = 1'b1;
        end
    end

endmodule

// File: rtl/dtlb_miss_sched.sv
// dtlb_miss_sched: shares one DTLB->L2-TLB miss port among REQ_NUM requesters.
//   req_valid/req_vpn/req_ready : miss requests; ready is combinational (merged or allocated)
//   flush                       : drops all pending misses
//   l2_req/l2_vpn/l2_tag        : registered walk request, held until l2_ready
//   l2_resp_*                   : walk response, matched on tag
//   wake_*                      : one-cycle wake pulse with waiter mask and status copies
//   busy                        : any entry valid or a walk in progress
// Handshake: a walk transfers on a cycle where l2_req and l2_ready are both high;
// l2_req/l2_vpn/l2_tag stay stable until that cycle.
module dtlb_miss_sched
    import dtlb_sched_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REQ_NUM-1:0]           req_valid,
    input  logic [REQ_NUM*VPN_WIDTH-1:0] req_vpn,
    output logic [REQ_NUM-1:0]           req_ready,
    input  logic                         flush,
    output logic                         l2_req,
    output logic [VPN_WIDTH-1:0]         l2_vpn,
    output logic [TAG_W-1:0]             l2_tag,
    input  logic                         l2_ready,
    input  logic                         l2_resp_valid,
    input  logic [TAG_W-1:0]             l2_resp_tag,
    input  logic                         l2_resp_exception,
    input  logic                         l2_resp_error,
    output logic                         wake_valid,
    output logic [REQ_NUM-1:0]           wake_mask,
    output logic                         wake_exception,
    output logic                         wake_error,
    output logic                         busy
);

    miss_entry_t [ENTRY_NUM-1:0] entries_q, entries_d, entries_acc;
    sched_state_e                state_q, state_d;
    logic                        l2_req_q, l2_req_d;
    logic [VPN_WIDTH-1:0]        l2_vpn_q, l2_vpn_d;
    logic [TAG_W-1:0]            l2_tag_q, l2_tag_d;
    logic                        wake_valid_q, wake_valid_d;
    logic [REQ_NUM-1:0]          wake_mask_q, wake_mask_d;
    logic                        wake_exc_q, wake_exc_d;
    logic                        wake_err_q, wake_err_d;

    logic                                resp_hit;
    logic [ENTRY_NUM-1:0]                free_now;
    logic [ENTRY_NUM-1:0][REQ_NUM-1:0]   merge_vec;
    logic [REQ_NUM-1:0]                  merge_hit;
    logic                                alloc_valid;
    logic [TAG_W-1:0]                    alloc_idx;
    logic [VPN_WIDTH-1:0]                alloc_vpn;
    logic [REQ_NUM-1:0]                  alloc_mask;
    logic [ENTRY_NUM-1:0]                pend;
    logic [TAG_W-1:0]                    issue_idx;

    assign resp_hit = (state_q == S_WAIT) && l2_resp_valid && (l2_resp_tag == l2_tag_q);
    // The completing entry is still valid this cycle but must not absorb new waiters.
    assign free_now = (resp_hit && !flush) ? (ENTRY_NUM'(1) << l2_tag_q) : '0;

    dtlb_miss_match u_match (
        .entries     (entries_q),
        .exclude     (free_now),
        .req_valid   (req_valid),
        .req_vpn     (req_vpn),
        .merge_vec   (merge_vec),
        .merge_hit   (merge_hit),
        .alloc_valid (alloc_valid),
        .alloc_idx   (alloc_idx),
        .alloc_vpn   (alloc_vpn),
        .alloc_mask  (alloc_mask)
    );

    assign req_ready = flush ? '0 : (merge_hit | alloc_mask);

    // Table after this cycle's merges, allocation and completion.
    always_comb begin
        entries_acc = entries_q;
        for (int e = 0; e < ENTRY_NUM; e++) begin
            entries_acc[e].waiters = entries_q[e].waiters | merge_vec[e];
            if (free_now[e]) entries_acc[e].valid = 1'b0;
        end
        if (alloc_valid) begin
            entries_acc[alloc_idx].valid   = 1'b1;
            entries_acc[alloc_idx].issued  = 1'b0;
            entries_acc[alloc_idx].vpn     = alloc_vpn;
            entries_acc[alloc_idx].waiters = alloc_mask;
        end
        for (int e = 0; e < ENTRY_NUM; e++) pend[e] = entries_acc[e].valid && !entries_acc[e].issued;
        issue_idx = TAG_W'(pr_lowest(32'(pend)));
    end

    always_comb begin
        entries_d    = flush ? '0 : entries_acc;
        state_d      = state_q;
        l2_req_d     = l2_req_q;
        l2_vpn_d     = l2_vpn_q;
        l2_tag_d     = l2_tag_q;
        wake_valid_d = 1'b0;
        wake_mask_d  = '0;
        wake_exc_d   = 1'b0;
        wake_err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!flush && (|pend)) begin
                    l2_req_d                  = 1'b1;
                    l2_vpn_d                  = entries_acc[issue_idx].vpn;
                    l2_tag_d                  = issue_idx;
                    entries_d[issue_idx].issued = 1'b1;
                    state_d                   = S_REQ;
                end
            end
            S_REQ: begin
                if (flush) begin
                    l2_req_d = 1'b0;
                    // A walk already handed over still owes us a response.
                    state_d  = l2_ready ? S_DRAIN : S_IDLE;
                end else if (l2_ready) begin
                    l2_req_d = 1'b0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = resp_hit ? S_IDLE : S_DRAIN;
                end else if (resp_hit) begin
                    wake_valid_d = 1'b1;
                    wake_mask_d  = entries_q[l2_tag_q].waiters;
                    wake_exc_d   = l2_resp_exception;
                    wake_err_d   = l2_resp_error;
                    state_d      = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (l2_resp_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) l2_req_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_q    <= '0;
            state_q      <= S_IDLE;
            l2_req_q     <= 1'b0;
            l2_vpn_q     <= '0;
            l2_tag_q     <= '0;
            wake_valid_q <= 1'b0;
            wake_mask_q  <= '0;
            wake_exc_q   <= 1'b0;
            wake_err_q   <= 1'b0;
        end else begin
            entries_q    <= entries_d;
            state_q      <= state_d;
            l2_req_q     <= l2_req_d;
            l2_vpn_q     <= l2_vpn_d;
            l2_tag_q     <= l2_tag_d;
            wake_valid_q <= wake_valid_d;
            wake_mask_q  <= wake_mask_d;
            wake_exc_q   <= wake_exc_d;
            wake_err_q   <= wake_err_d;
        end
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        for (int e = 0; e < ENTRY_NUM; e++) busy = busy | entries_q[e].valid;
    end

    assign l2_req         = l2_req_q;
    assign l2_vpn         = l2_vpn_q;
    assign l2_tag         = l2_tag_q;
    assign wake_valid     = wake_valid_q;
    assign wake_mask      = wake_mask_q;
    assign wake_exception = wake_exc_q;
    assign wake_error     = wake_err_q;

endmodule

// File: tb/tb_dtlb_miss_sched.sv
// tb_dtlb_miss_sched: directed scenarios plus randomized traffic against a
// transaction-level model of the miss table and the single outstanding walk.
module tb_dtlb_miss_sched;
  import dtlb_sched_pkg::*;

  localparam int R = REQ_NUM;
  localparam int E = ENTRY_NUM;
  localparam int V = VPN_WIDTH;
  localparam int T = TAG_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [R-1:0]   req_valid;
  logic [R*V-1:0] req_vpn;
  logic [R-1:0]   req_ready;
  logic           flush;
  logic           l2_req;
  logic [V-1:0]   l2_vpn;
  logic [T-1:0]   l2_tag;
  logic           l2_ready;
  logic           l2_resp_valid;
  logic [T-1:0]   l2_resp_tag;
  logic           l2_resp_exception;
  logic           l2_resp_error;
  logic           wake_valid;
  logic [R-1:0]   wake_mask;
  logic           wake_exception;
  logic           wake_error;
  logic           busy;
  logic [V-1:0]   vpn_in [R];

  always_comb begin
    for (int i = 0; i < R; i++) req_vpn[i*V +: V] = vpn_in[i];
  end

  dtlb_miss_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_vpn(req_vpn), .req_ready(req_ready),
    .flush(flush), .l2_req(l2_req), .l2_vpn(l2_vpn), .l2_tag(l2_tag), .l2_ready(l2_ready),
    .l2_resp_valid(l2_resp_valid), .l2_resp_tag(l2_resp_tag),
    .l2_resp_exception(l2_resp_exception), .l2_resp_error(l2_resp_error),
    .wake_valid(wake_valid), .wake_mask(wake_mask), .wake_exception(wake_exception),
    .wake_error(wake_error), .busy(busy)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [R-1:0] exp_q[$];   // wake masks the model has produced, in order

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Walk status: 0 no walk, 1 request offered, 2 request taken / awaiting answer,
  // 3 answer owed for a flushed walk.
  bit           m_valid [E];
  bit           m_issued[E];
  logic [V-1:0] m_vpn   [E];
  logic [R-1:0] m_wait  [E];
  int           walk;
  bit           e_l2_req;
  logic [V-1:0] e_l2_vpn;
  logic [T-1:0] e_l2_tag;
  bit           e_wake;
  logic [R-1:0] e_mask;
  bit           e_exc, e_err;
  int           resp_cnt;
  logic [T-1:0] resp_tag_sched;

  task automatic model_reset();
    for (int e = 0; e < E; e++) begin
      m_valid[e] = 0; m_issued[e] = 0; m_vpn[e] = '0; m_wait[e] = '0;
    end
    walk = 0; e_l2_req = 0; e_l2_vpn = '0; e_l2_tag = '0;
    e_wake = 0; e_mask = '0; e_exc = 0; e_err = 0;
  endtask

  task automatic schedule_resp(input logic [T-1:0] tag);
    resp_cnt       = int'($urandom_range(1, 4));
    resp_tag_sched = tag;
  endtask

  // Evaluates the current cycle's inputs: checks req_ready, then advances the model.
  task automatic model_step();
    int           freed = -1;
    int           hit_e[R];
    int           first = -1;
    int           fe = -1;
    int           old_walk = walk;
    logic [R-1:0] exp_rdy = '0;
    logic [R-1:0] joiners = '0;

    if (walk == 2 && !flush && l2_resp_valid && l2_resp_tag == e_l2_tag) freed = int'(e_l2_tag);
    for (int i = 0; i < R; i++) hit_e[i] = -1;
    if (!flush) begin
      for (int i = 0; i < R; i++) begin
        if (req_valid[i]) begin
          for (int e = 0; e < E; e++)
            if (hit_e[i] < 0 && m_valid[e] && e != freed && m_vpn[e] == vpn_in[i]) hit_e[i] = e;
          if (hit_e[i] >= 0) exp_rdy[i] = 1'b1;
          else if (first < 0) first = i;
        end
      end
      for (int e = 0; e < E; e++) if (fe < 0 && !m_valid[e]) fe = e;
      if (first >= 0 && fe >= 0)
        for (int i = 0; i < R; i++)
          if (req_valid[i] && hit_e[i] < 0 && vpn_in[i] == vpn_in[first]) joiners[i] = 1'b1;
      exp_rdy = exp_rdy | joiners;
    end
    check_eq("req_ready", req_ready, exp_rdy);

    e_wake = 0; e_mask = '0; e_exc = 0; e_err = 0;
    if (flush) begin
      for (int e = 0; e < E; e++) m_valid[e] = 0;
      e_l2_req = 0;
      case (old_walk)
        1: if (l2_ready) begin walk = 3; schedule_resp(e_l2_tag); end else walk = 0;
        2: walk = (l2_resp_valid && l2_resp_tag == e_l2_tag) ? 0 : 3;
        3: if (l2_resp_valid) walk = 0;
        default: walk = 0;
      endcase
    end else begin
      for (int i = 0; i < R; i++) if (hit_e[i] >= 0) m_wait[hit_e[i]][i] = 1'b1;
      if (joiners != '0) begin
        m_valid[fe] = 1; m_issued[fe] = 0; m_vpn[fe] = vpn_in[first]; m_wait[fe] = joiners;
      end
      if (freed >= 0) begin
        e_wake = 1; e_mask = m_wait[freed]; e_exc = l2_resp_exception; e_err = l2_resp_error;
        exp_q.push_back(m_wait[freed]);
        m_valid[freed] = 0;
        walk = 0;
      end
      case (old_walk)
        0: begin
          for (int e = 0; e < E; e++) begin
            if (walk == 0 && m_valid[e] && !m_issued[e]) begin
              m_issued[e] = 1; e_l2_req = 1; e_l2_vpn = m_vpn[e]; e_l2_tag = T'(e); walk = 1;
            end
          end
        end
        1: if (l2_ready) begin e_l2_req = 0; walk = 2; schedule_resp(e_l2_tag); end
        3: if (l2_resp_valid) walk = 0;
        default: ;
      endcase
    end
  endtask

  task automatic check_regs();
    bit any_valid = 0;
    check_eq("l2_req", l2_req, e_l2_req);
    if (e_l2_req) begin
      check_eq("l2_vpn", l2_vpn, e_l2_vpn);
      check_eq("l2_tag", l2_tag, e_l2_tag);
    end
    check_eq("wake_valid", wake_valid, e_wake);
    if (e_wake) begin
      check_eq("wake_mask", wake_mask, e_mask);
      check_eq("wake_exception", wake_exception, e_exc);
      check_eq("wake_error", wake_error, e_err);
    end
    if (wake_valid) begin
      if (exp_q.size() == 0) check_eq("wake_unexpected", wake_valid, 1'b0);
      else check_eq("wake_sb_mask", wake_mask, exp_q.pop_front());
    end
    for (int e = 0; e < E; e++) any_valid |= m_valid[e];
    check_eq("busy", busy, any_valid || walk != 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    req_valid = '0; flush = 0; l2_ready = 0;
    l2_resp_valid = 0; l2_resp_tag = '0; l2_resp_exception = 0; l2_resp_error = 0;
    for (int i = 0; i < R; i++) vpn_in[i] = '0;
  endtask

  task automatic tick();
    #1;
    model_step();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic drive_resp(input logic [T-1:0] tag, input bit exc, input bit err);
    l2_resp_valid = 1; l2_resp_tag = tag; l2_resp_exception = exc; l2_resp_error = err;
  endtask

  task automatic drive_random();
    logic [V-1:0] pool [6];
    pool[0] = 27'h40; pool[1] = 27'h77; pool[2] = 27'h123;
    pool[3] = 27'h5555; pool[4] = 27'h7ffffff; pool[5] = 27'h0;
    clear_inputs();
    for (int i = 0; i < R; i++) begin
      req_valid[i] = ($urandom_range(0, 9) < 4);
      vpn_in[i]    = pool[$urandom_range(0, 5)];
    end
    flush    = ($urandom_range(0, 39) == 0);
    l2_ready = ($urandom_range(0, 1) == 1);
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) drive_resp(resp_tag_sched, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end else if ($urandom_range(0, 24) == 0) begin
      drive_resp(e_l2_tag ^ T'(1), 0, 0);   // stray answer with a tag other than the live walk
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    resp_cnt = 0;
    resp_tag_sched = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_regs();
    check_eq("rst_wake_mask", wake_mask, '0);
    check_eq("rst_req_ready", req_ready, '0);
    rst = 0;

    // single miss, exception reported
    clear_inputs(); req_valid = 4'b0001; vpn_in[0] = 27'h123; l2_ready = 1; tick();
    check_eq("dir_single_tag", l2_tag, 0);
    clear_inputs(); l2_ready = 1; tick();
    clear_inputs(); tick();
    drive_resp(0, 1, 0); tick();
    check_eq("dir_single_mask", wake_mask, 4'b0001);
    check_eq("dir_single_exc", wake_exception, 1'b1);
    clear_inputs(); tick();
    check_eq("dir_single_idle", busy, 1'b0);

    // merge: two in the same cycle, one more while waiting; wrong tag first
    clear_inputs(); req_valid = 4'b0101; vpn_in[0] = 27'h40; vpn_in[2] = 27'h40; tick();
    clear_inputs(); l2_ready = 1; tick();
    clear_inputs(); req_valid = 4'b0010; vpn_in[1] = 27'h40; tick();
    clear_inputs(); drive_resp(2, 0, 0); tick();
    check_eq("dir_wrong_tag", wake_valid, 1'b0);
    clear_inputs(); drive_resp(0, 0, 1); tick();
    check_eq("dir_merge_mask", wake_mask, 4'b0111);
    check_eq("dir_merge_err", wake_error, 1'b1);
    clear_inputs(); tick();

    // backpressure: request held stable
    clear_inputs(); req_valid = 4'b0001; vpn_in[0] = 27'h99; tick();
    for (int k = 0; k < 5; k++) begin
      clear_inputs(); tick();
      check_eq("dir_bp_vpn", l2_vpn, 27'h99);
    end
    clear_inputs(); l2_ready = 1; tick();
    clear_inputs(); drive_resp(0, 0, 0); tick();
    clear_inputs(); tick();

    // flush while waiting, new miss waits for the stale answer
    clear_inputs(); req_valid = 4'b0011; vpn_in[0] = 27'hA; vpn_in[1] = 27'hB; tick();
    clear_inputs(); l2_ready = 1; tick();
    clear_inputs(); flush = 1; tick();
    clear_inputs(); req_valid = 4'b0001; vpn_in[0] = 27'h77; tick();
    clear_inputs(); tick();
    check_eq("dir_drain_noreq", l2_req, 1'b0);
    clear_inputs(); drive_resp(0, 0, 0); tick();
    check_eq("dir_drain_nowake", wake_valid, 1'b0);
    clear_inputs(); tick();
    check_eq("dir_after_drain_req", l2_req, 1'b1);
    check_eq("dir_after_drain_vpn", l2_vpn, 27'h77);
    clear_inputs(); l2_ready = 1; tick();
    clear_inputs(); drive_resp(0, 0, 0); tick();
    clear_inputs(); tick();

    // randomized traffic with one asynchronous reset mid-run
    resp_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        rst = 1;
        #1;
        model_reset();
        check_regs();
        rst = 0;
        #1;
      end
      drive_random();
      tick();
    end

    clear_inputs();
    for (int k = 0; k < 10; k++) tick();
    check_eq("wake_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
